// File: rtl/store_drain_if.sv
// Bundles the store-in, memory-write and snoop signals of the store drain unit.
interface store_drain_if #(
    parameter int unsigned ADDR_LEN = 32,
    parameter int unsigned DATA_LEN = 32
);
    localparam int unsigned BE_LEN = DATA_LEN / 8;

    logic                in_valid;
    logic                in_ready;
    logic [ADDR_LEN-1:0] in_addr;
    logic [DATA_LEN-1:0] in_data;
    logic [BE_LEN-1:0]   in_be;

    logic                mem_req;
    logic [ADDR_LEN-1:0] mem_addr;
    logic [DATA_LEN-1:0] mem_wdata;
    logic [BE_LEN-1:0]   mem_be;
    logic                mem_ack;

    logic [ADDR_LEN-1:0] snoop_addr;
    logic                snoop_hit;
    logic [DATA_LEN-1:0] snoop_data;
    logic [BE_LEN-1:0]   snoop_be;

    modport master (
        output in_valid, in_addr, in_data, in_be, mem_ack, snoop_addr,
        input  in_ready, mem_req, mem_addr, mem_wdata, mem_be,
               snoop_hit, snoop_data, snoop_be
    );

    modport slave (
        input  in_valid, in_addr, in_data, in_be, mem_ack, snoop_addr,
        output in_ready, mem_req, mem_addr, mem_wdata, mem_be,
               snoop_hit, snoop_data, snoop_be
    );
endinterface

// File: rtl/store_drain_unit.sv
// In-order FIFO of committed stores drained to data memory over req/ack,
// with a combinational youngest-match snoop port for load forwarding.
module store_drain_unit #(
    parameter int unsigned ADDR_LEN   = 32,
    parameter int unsigned DATA_LEN   = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DEPTH_BITS = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    store_drain_if.slave          sd,
    output logic [DEPTH_BITS:0]   count_o,
    output logic                  busy_o
);
    localparam int unsigned BE_LEN = DATA_LEN / 8;
    localparam logic [DEPTH_BITS:0] CNT_FULL = (DEPTH_BITS+1)'(DEPTH);

    typedef struct packed {
        logic [ADDR_LEN-1:0] addr;
        logic [DATA_LEN-1:0] data;
        logic [BE_LEN-1:0]   be;
    } entry_t;

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    entry_t                mem_q [DEPTH];
    entry_t                head;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] snp_idx;
    logic [DEPTH_BITS:0]   count_q;
    logic [DEPTH_BITS:0]   count_d;
    logic                  ready_en;
    logic                  busy_q;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic                  unused_snoop_lsb;
    state_t                state_q;
    state_t                state_d;

    // ready_en keeps in_ready low until the first edge after reset release
    assign sd.in_ready = ready_en && (count_q < CNT_FULL);
    assign push        = sd.in_valid && sd.in_ready && (sd.in_be != '0);
    assign pop         = issue && sd.mem_ack;
    assign count_d     = count_q + (DEPTH_BITS+1)'(push) - (DEPTH_BITS+1)'(pop);
    assign head        = mem_q[rd_ptr];

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
            ready_en <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            count_q  <= count_d;
            busy_q   <= (count_d != '0);
            if (push) wr_ptr <= wr_ptr + DEPTH_BITS'(1);
            if (pop)  rd_ptr <= rd_ptr + DEPTH_BITS'(1);
        end
    end

    // Storage needs no reset: entries are only visible below count_q
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr] <= '{addr: sd.in_addr, data: sd.in_data, be: sd.in_be};
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_d != '0) state_d = ISSUE;
            ISSUE:   if (count_d == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue = 1'b0;
        case (state_q)
            ISSUE:   issue = 1'b1;
            default: issue = 1'b0;
        endcase
    end

    assign sd.mem_req   = issue;
    assign sd.mem_addr  = issue ? head.addr : '0;
    assign sd.mem_wdata = issue ? head.data : '0;
    assign sd.mem_be    = issue ? head.be   : '0;

    // Scan oldest to youngest so the last match left standing is the youngest
    always_comb begin
        sd.snoop_hit  = 1'b0;
        sd.snoop_data = '0;
        sd.snoop_be   = '0;
        snp_idx       = rd_ptr;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            snp_idx = rd_ptr + DEPTH_BITS'(k);
            if (((DEPTH_BITS+1)'(k) < count_q) &&
                (mem_q[snp_idx].addr[ADDR_LEN-1:2] == sd.snoop_addr[ADDR_LEN-1:2])) begin
                sd.snoop_hit  = 1'b1;
                sd.snoop_data = mem_q[snp_idx].data;
                sd.snoop_be   = mem_q[snp_idx].be;
            end
        end
    end

    assign unused_snoop_lsb = ^sd.snoop_addr[1:0];

    assign count_o = count_q;
    assign busy_o  = busy_q;
endmodule

// File: tb/tb_store_drain_unit.sv
// Self-checking bench for store_drain_unit against a queue-based reference model.
module tb_store_drain_unit;
    localparam int unsigned ADDR_LEN   = 32;
    localparam int unsigned DATA_LEN   = 32;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned DEPTH_BITS = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [2:0] count_o;
    logic       busy_o;
    int         total = 0;
    int         bad   = 0;

    ent_t mq[$];
    bit   rdy_en;

    store_drain_if #(.ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN)) sd();

    store_drain_unit #(
        .ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN), .DEPTH(DEPTH), .DEPTH_BITS(DEPTH_BITS)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .sd(sd), .count_o(count_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic bit exp_ready();
        return rdy_en && (mq.size() < DEPTH);
    endfunction

    function automatic ent_t snoop_ref(input logic [31:0] a, output bit hit);
        ent_t r;
        r   = '0;
        hit = 1'b0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].addr[31:2] == a[31:2]) begin
                r   = mq[i];
                hit = 1'b1;
                break;
            end
        end
        return r;
    endfunction

    task automatic model_edge();
        bit   do_push;
        bit   do_pop;
        ent_t e;
        if (!reset_i) begin
            mq.delete();
            rdy_en = 1'b0;
            return;
        end
        do_push = sd.in_valid && exp_ready() && (sd.in_be != 4'h0);
        do_pop  = (mq.size() != 0) && sd.mem_ack;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            e.addr = sd.in_addr;
            e.data = sd.in_data;
            e.be   = sd.in_be;
            mq.push_back(e);
        end
        rdy_en = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        sd.in_valid = v;
        sd.in_addr  = a;
        sd.in_data  = d;
        sd.in_be    = be;
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        sd.mem_ack    = 1'b0;
        sd.snoop_addr = 32'h0;
        mq.delete();
        rdy_en = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        total++; if (sd.mem_req !== 1'b0)  begin bad++; $display("FAIL reset_req: got %b want 0", sd.mem_req); end
        total++; if (sd.in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", sd.in_ready); end
        total++; if (count_o !== 3'd0)     begin bad++; $display("FAIL reset_count: got %0d want 0", count_o); end
        total++; if (busy_o !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        total++; if (sd.snoop_hit !== 1'b0) begin bad++; $display("FAIL reset_hit: got %b want 0", sd.snoop_hit); end
        total++; if (sd.mem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", sd.mem_addr); end
        #2 reset_i = 1'b1;
        #1;
        total++; if (sd.in_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge: got %b want 0", sd.in_ready); end
        tick();
        total++; if (sd.in_ready !== 1'b1) begin bad++; $display("FAIL ready_after_edge: got %b want 1", sd.in_ready); end
    endtask

    task automatic test_single_write();
        sd.mem_ack = 1'b1;
        drive(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        total++; if (sd.mem_req !== 1'b1)          begin bad++; $display("FAIL single_req: got %b want 1", sd.mem_req); end
        total++; if (sd.mem_addr !== 32'h100)      begin bad++; $display("FAIL single_addr: got %h want 100", sd.mem_addr); end
        total++; if (sd.mem_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data: got %h want deadbeef", sd.mem_wdata); end
        total++; if (sd.mem_be !== 4'hF)           begin bad++; $display("FAIL single_be: got %h want f", sd.mem_be); end
        tick();
        total++; if (sd.mem_req !== 1'b0) begin bad++; $display("FAIL single_req_drop: got %b want 0", sd.mem_req); end
        total++; if (count_o !== 3'd0)    begin bad++; $display("FAIL single_count: got %0d want 0", count_o); end
        total++; if (busy_o !== 1'b0)     begin bad++; $display("FAIL single_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_full_stall();
        logic [31:0] exp_addr [4];
        int          seen;
        exp_addr = '{32'h10, 32'h14, 32'h18, 32'h1C};
        sd.mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, exp_addr[i], 32'hA000_0000 + 32'(i), 4'hF);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        total++; if (sd.in_ready !== 1'b0)   begin bad++; $display("FAIL full_ready: got %b want 0", sd.in_ready); end
        total++; if (count_o !== 3'd4)       begin bad++; $display("FAIL full_count: got %0d want 4", count_o); end
        total++; if (sd.mem_addr !== 32'h10) begin bad++; $display("FAIL full_head: got %h want 10", sd.mem_addr); end
        tick();
        total++; if (sd.mem_addr !== 32'h10) begin bad++; $display("FAIL stall_hold: got %h want 10", sd.mem_addr); end
        sd.mem_ack = 1'b1;
        tick();
        sd.mem_ack = 1'b0;
        #1;
        total++; if (sd.mem_addr !== 32'h14) begin bad++; $display("FAIL pulse_head: got %h want 14", sd.mem_addr); end
        total++; if (sd.in_ready !== 1'b1)   begin bad++; $display("FAIL pulse_ready: got %b want 1", sd.in_ready); end
        total++; if (count_o !== 3'd3)       begin bad++; $display("FAIL pulse_count: got %0d want 3", count_o); end
        sd.mem_ack = 1'b1;
        seen = 1;
        for (int c = 0; c < 8 && seen < 4; c++) begin
            #1;
            total++;
            if (sd.mem_req !== 1'b1 || sd.mem_addr !== exp_addr[seen]) begin
                bad++; $display("FAIL drain_order: got req=%b addr=%h want req=1 addr=%h", sd.mem_req, sd.mem_addr, exp_addr[seen]);
            end
            seen++;
            tick();
        end
        total++; if (count_o !== 3'd0) begin bad++; $display("FAIL drain_empty: got %0d want 0", count_o); end
    endtask

    task automatic test_snoop();
        sd.mem_ack = 1'b0;
        drive(1'b1, 32'h200, 32'h11111111, 4'hF); tick();
        drive(1'b1, 32'h200, 32'h22220000, 4'hC); tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        sd.snoop_addr = 32'h202;
        #1;
        total++; if (sd.snoop_hit !== 1'b1)           begin bad++; $display("FAIL snoop_hit: got %b want 1", sd.snoop_hit); end
        total++; if (sd.snoop_data !== 32'h22220000)  begin bad++; $display("FAIL snoop_data: got %h want 22220000", sd.snoop_data); end
        total++; if (sd.snoop_be !== 4'hC)            begin bad++; $display("FAIL snoop_be: got %h want c", sd.snoop_be); end
        sd.snoop_addr = 32'h300;
        #1;
        total++; if (sd.snoop_hit !== 1'b0 || sd.snoop_data !== 32'h0 || sd.snoop_be !== 4'h0) begin
            bad++; $display("FAIL snoop_miss: got hit=%b data=%h be=%h want 0/0/0", sd.snoop_hit, sd.snoop_data, sd.snoop_be);
        end
        sd.snoop_addr = 32'h200;
        sd.mem_ack = 1'b1;
        tick();
        #1;
        // last remaining entry sits in its ack cycle and must still be visible
        total++; if (sd.snoop_hit !== 1'b1 || sd.snoop_data !== 32'h22220000) begin
            bad++; $display("FAIL snoop_ack_cycle: got hit=%b data=%h want 1/22220000", sd.snoop_hit, sd.snoop_data);
        end
        tick();
        total++; if (sd.snoop_hit !== 1'b0) begin bad++; $display("FAIL snoop_after_pop: got %b want 0", sd.snoop_hit); end
    endtask

    task automatic test_back_to_back();
        ent_t exp_q [9];
        int   w;
        bit   started;
        for (int i = 0; i < 9; i++) begin
            exp_q[i].addr = 32'h400 + 32'(4 * i);
            exp_q[i].data = $urandom;
            exp_q[i].be   = 4'(1 + $urandom_range(0, 14));
        end
        sd.mem_ack = 1'b1;
        w = 0;
        started = 1'b0;
        drive(1'b1, exp_q[0].addr, exp_q[0].data, exp_q[0].be);
        for (int c = 0; c < 14; c++) begin
            tick();
            if (c + 1 < 9) drive(1'b1, exp_q[c+1].addr, exp_q[c+1].data, exp_q[c+1].be);
            else           drive(1'b0, 32'h0, 32'h0, 4'h0);
            #1;
            if (sd.mem_req === 1'b1 && w < 9) begin
                started = 1'b1;
                total++;
                if (sd.mem_addr !== exp_q[w].addr || sd.mem_wdata !== exp_q[w].data || sd.mem_be !== exp_q[w].be) begin
                    bad++; $display("FAIL b2b_write%0d: got %h/%h/%h want %h/%h/%h", w, sd.mem_addr, sd.mem_wdata, sd.mem_be,
                                    exp_q[w].addr, exp_q[w].data, exp_q[w].be);
                end
                w++;
            end else if (started && w < 9) begin
                total++; bad++; $display("FAIL b2b_gap: got req=%b want 1 before write %0d", sd.mem_req, w);
            end
        end
        total++; if (w != 9) begin bad++; $display("FAIL b2b_count: got %0d want 9", w); end
    endtask

    task automatic test_zero_be();
        sd.mem_ack = 1'b1;
        drive(1'b1, 32'h500, 32'h12345678, 4'h0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        total++; if (count_o !== 3'd0)    begin bad++; $display("FAIL zbe_count: got %0d want 0", count_o); end
        total++; if (sd.mem_req !== 1'b0) begin bad++; $display("FAIL zbe_req: got %b want 0", sd.mem_req); end
        tick();
        total++; if (sd.mem_req !== 1'b0) begin bad++; $display("FAIL zbe_req_later: got %b want 0", sd.mem_req); end
    endtask

    task automatic test_async_reset();
        sd.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h700 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'hF);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        sd.snoop_addr = 32'h704;
        #1;
        total++; if (sd.mem_req !== 1'b1 || count_o !== 3'd3) begin
            bad++; $display("FAIL pre_reset: got req=%b count=%0d want 1/3", sd.mem_req, count_o);
        end
        #1 reset_i = 1'b0;
        mq.delete();
        rdy_en = 1'b0;
        #1;
        total++; if (sd.mem_req !== 1'b0)   begin bad++; $display("FAIL areset_req: got %b want 0", sd.mem_req); end
        total++; if (count_o !== 3'd0)      begin bad++; $display("FAIL areset_count: got %0d want 0", count_o); end
        total++; if (sd.snoop_hit !== 1'b0) begin bad++; $display("FAIL areset_hit: got %b want 0", sd.snoop_hit); end
        total++; if (sd.in_ready !== 1'b0)  begin bad++; $display("FAIL areset_ready: got %b want 0", sd.in_ready); end
        #2 reset_i = 1'b1;
        sd.mem_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (sd.mem_req !== 1'b0 || count_o !== 3'd0) begin
                bad++; $display("FAIL stale_write: got req=%b count=%0d want 0/0", sd.mem_req, count_o);
            end
        end
    endtask

    task automatic test_random();
        ent_t exp_s;
        bit   exp_hit;
        for (int c = 0; c < 400; c++) begin
            tick();
            drive($urandom_range(0, 9) < 6, 32'h600 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3)),
                  $urandom, ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom));
            sd.mem_ack    = $urandom_range(0, 1) == 1;
            sd.snoop_addr = 32'h600 + 32'(4 * $urandom_range(0, 4)) + 32'($urandom_range(0, 3));
            #1;
            exp_s = snoop_ref(sd.snoop_addr, exp_hit);
            total++; if (sd.in_ready !== exp_ready()) begin bad++; $display("FAIL rnd_ready@%0d: got %b want %b", c, sd.in_ready, exp_ready()); end
            total++; if (count_o !== 3'(mq.size()))    begin bad++; $display("FAIL rnd_count@%0d: got %0d want %0d", c, count_o, mq.size()); end
            total++; if (busy_o !== (mq.size() != 0))  begin bad++; $display("FAIL rnd_busy@%0d: got %b want %b", c, busy_o, mq.size() != 0); end
            total++; if (sd.mem_req !== (mq.size() != 0)) begin bad++; $display("FAIL rnd_req@%0d: got %b want %b", c, sd.mem_req, mq.size() != 0); end
            if (mq.size() != 0) begin
                total++;
                if (sd.mem_addr !== mq[0].addr || sd.mem_wdata !== mq[0].data || sd.mem_be !== mq[0].be) begin
                    bad++; $display("FAIL rnd_head@%0d: got %h/%h/%h want %h/%h/%h", c, sd.mem_addr, sd.mem_wdata, sd.mem_be,
                                    mq[0].addr, mq[0].data, mq[0].be);
                end
            end
            total++;
            if (sd.snoop_hit !== exp_hit || sd.snoop_data !== exp_s.data || sd.snoop_be !== exp_s.be) begin
                bad++; $display("FAIL rnd_snoop@%0d: got %b/%h/%h want %b/%h/%h", c, sd.snoop_hit, sd.snoop_data, sd.snoop_be,
                                exp_hit, exp_s.data, exp_s.be);
            end
        end
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        sd.mem_ack = 1'b1;
        for (int c = 0; c < 10 && mq.size() != 0; c++) tick();
        tick();
        total++; if (count_o !== 3'd0 || mq.size() != 0) begin
            bad++; $display("FAIL rnd_drain: got count=%0d model=%0d want 0", count_o, mq.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_full_stall();
        test_snoop();
        test_back_to_back();
        test_zero_be();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
